// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Runtime-reconfigurable bank of NUM_CLKS integer clock dividers
//            driven from one reference clock. All channels restart together
//            after every (re)alignment, so channels whose ratios share a
//            common multiple strobe together again at that multiple. A lock
//            flag reports that the bank has run undisturbed for LOCK_CYCLES.
// Ports    : refclk      - sole clock
//            rst         - asynchronous active-high reset
//            div_cfg     - new divisors, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//            cfg_valid   - div_cfg valid
//            cfg_ready   - config can be accepted this cycle (RUN state)
//            sync_req    - realign all channels, divisors unchanged
//            outclk      - divided clocks (registered, glitch-free)
//            outclk_stb  - one-cycle pulse with each outclk rising edge
//            locked      - bank aligned and running for >= LOCK_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
    parameter int                              NUM_CLKS    = 3,
    parameter int                              DIV_WIDTH   = 16,
    parameter logic [NUM_CLKS*DIV_WIDTH-1:0]   DEFAULT_DIV = {16'd100, 16'd4, 16'd1},
    parameter int                              LOCK_CYCLES = 1024
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic [NUM_CLKS*DIV_WIDTH-1:0]   div_cfg,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic                            sync_req,
    output logic [NUM_CLKS-1:0]             outclk,
    output logic [NUM_CLKS-1:0]             outclk_stb,
    output logic                            locked
);

    localparam int                  LK_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LK_W-1:0]     C_LK_MAX  = LK_W'(LOCK_CYCLES);
    localparam logic [LK_W-1:0]     C_LK_ONE  = LK_W'(1);
    localparam logic [DIV_WIDTH-1:0] C_DIV_ONE = DIV_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e          state_q;
    logic            cfg_ready_q;
    logic            locked_q;
    logic [LK_W-1:0] lk_cnt_q;
    logic [LK_W-1:0] lk_cnt_d;

    logic            cfg_fire;
    logic            realign;

    // cfg_ready_q is only high in RUN, so a handshake implies RUN.
    assign cfg_fire = cfg_valid && cfg_ready_q;
    // A config and a sync request in the same cycle share one ALIGN.
    assign realign  = (state_q == ST_RUN) && (cfg_fire || sync_req);

    // Saturating run-time counter behind the lock flag.
    assign lk_cnt_d = (lk_cnt_q == C_LK_MAX) ? lk_cnt_q : (lk_cnt_q + C_LK_ONE);

    // ------------------------------------------------------------------------
    // Control FSM: ALIGN is a single-cycle state that always falls into RUN.
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ALIGN;
            cfg_ready_q <= 1'b0;
            locked_q    <= 1'b0;
            lk_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_ALIGN: begin
                    state_q     <= ST_RUN;
                    cfg_ready_q <= 1'b1;
                    lk_cnt_q    <= '0;
                    // k=0 can never be locked since LOCK_CYCLES >= 1.
                    locked_q    <= 1'b0;
                end
                ST_RUN: begin
                    if (realign) begin
                        state_q     <= ST_ALIGN;
                        cfg_ready_q <= 1'b0;
                        lk_cnt_q    <= '0;
                        locked_q    <= 1'b0;
                    end else begin
                        lk_cnt_q <= lk_cnt_d;
                        locked_q <= (lk_cnt_d == C_LK_MAX);
                    end
                end
                default: begin
                    state_q     <= ST_ALIGN;
                    cfg_ready_q <= 1'b0;
                    lk_cnt_q    <= '0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign locked    = locked_q;

    // ------------------------------------------------------------------------
    // Per-channel dividers. cnt_q holds (k mod D) for the cycle currently on
    // the outputs; the outputs are computed from the next count so that they
    // are registered and line up with the counter.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] div_q;
        logic [DIV_WIDTH-1:0] cnt_q;
        logic [DIV_WIDTH-1:0] cnt_d;
        logic [DIV_WIDTH-1:0] half_c;
        logic                 en_c;
        logic                 clk_q;
        logic                 stb_q;

        assign en_c   = (div_q != '0);
        // ceil(D/2); fits in DIV_WIDTH even for D = 2^DIV_WIDTH-1.
        assign half_c = (div_q >> 1) + DIV_WIDTH'(div_q[0]);

        // Wrap at D-1 so the count never exceeds D-1 and cannot overflow.
        always_comb begin
            cnt_d = '0;
            if (en_c && (cnt_q != (div_q - C_DIV_ONE))) begin
                cnt_d = cnt_q + C_DIV_ONE;
            end
        end

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                div_q <= DEFAULT_DIV[i*DIV_WIDTH +: DIV_WIDTH];
                cnt_q <= '0;
                clk_q <= 1'b0;
                stb_q <= 1'b0;
            end else begin
                if (cfg_fire) begin
                    div_q <= div_cfg[i*DIV_WIDTH +: DIV_WIDTH];
                end
                if (state_q == ST_ALIGN) begin
                    // Leaving ALIGN: k=0, every enabled channel strobes high.
                    cnt_q <= '0;
                    clk_q <= en_c;
                    stb_q <= en_c;
                end else if (realign) begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                    stb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    clk_q <= en_c && (cnt_d < half_c);
                    stb_q <= en_c && (cnt_d == '0);
                end
            end
        end

        assign outclk[i]     = clk_q;
        assign outclk_stb[i] = stb_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Purpose  : Directed, self-checking bench for clk_div_bank. A 3-channel
//            16-bit instance covers defaults, reconfiguration, sync, combined
//            cfg+sync and asynchronous reset; a 1-channel 4-bit instance
//            covers the maximum divisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int LOCK_A = 16;
    localparam int LOCK_B = 4;

    logic        refclk;
    logic        rst;
    logic [47:0] div_cfg;
    logic        cfg_valid;
    logic        sync_req;
    wire         cfg_ready;
    wire  [2:0]  outclk;
    wire  [2:0]  outclk_stb;
    wire         locked;

    logic [3:0]  div_cfg_b;
    logic        cfg_valid_b;
    logic        sync_req_b;
    wire         cfg_ready_b;
    wire  [0:0]  outclk_b;
    wire  [0:0]  outclk_stb_b;
    wire         locked_b;

    wire  [7:0]  obs_a = {outclk, outclk_stb, locked, cfg_ready};
    wire  [3:0]  obs_b = {outclk_b, outclk_stb_b, locked_b, cfg_ready_b};

    int checks = 0;
    int errors = 0;

    clk_div_bank #(
        .NUM_CLKS    (3),
        .DIV_WIDTH   (16),
        .DEFAULT_DIV ({16'd100, 16'd4, 16'd1}),
        .LOCK_CYCLES (LOCK_A)
    ) u_dut (
        .refclk     (refclk),
        .rst        (rst),
        .div_cfg    (div_cfg),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .sync_req   (sync_req),
        .outclk     (outclk),
        .outclk_stb (outclk_stb),
        .locked     (locked)
    );

    clk_div_bank #(
        .NUM_CLKS    (1),
        .DIV_WIDTH   (4),
        .DEFAULT_DIV (4'd15),
        .LOCK_CYCLES (LOCK_B)
    ) u_dut_max (
        .refclk     (refclk),
        .rst        (rst),
        .div_cfg    (div_cfg_b),
        .cfg_valid  (cfg_valid_b),
        .cfg_ready  (cfg_ready_b),
        .sync_req   (sync_req_b),
        .outclk     (outclk_b),
        .outclk_stb (outclk_stb_b),
        .locked     (locked_b)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        int         k;
        logic [2:0] exp_clk;
        logic [2:0] exp_stb;
    } vec_t;

    vec_t odd_tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Expected {outclk, outclk_stb, locked, cfg_ready} at RUN cycle k.
    function automatic logic [7:0] exp_a(input int k, input int d0, input int d1, input int d2);
        int         d[3];
        logic [2:0] c;
        logic [2:0] s;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        for (int i = 0; i < 3; i++) begin
            if (d[i] == 0) begin
                c[i] = 1'b0;
                s[i] = 1'b0;
            end else begin
                c[i] = ((k % d[i]) < ((d[i] + 1) / 2));
                s[i] = ((k % d[i]) == 0);
            end
        end
        return {c, s, (k >= LOCK_A), 1'b1};
    endfunction

    // Checks RUN cycles k0 .. k0+n-1, leaving the bench at cycle k0+n.
    task automatic run_check(input string nm, input int k0, input int n,
                             input int d0, input int d1, input int d2);
        for (int k = k0; k < k0 + n; k++) begin
            chk($sformatf("%s k=%0d", nm, k), obs_a, exp_a(k, d0, d1, d2));
            tick();
        end
    endtask

    initial begin
        // Divisors {ch2,ch1,ch0} = {0,7,3}
        odd_tbl[0] = '{0, 3'b011, 3'b011};
        odd_tbl[1] = '{1, 3'b011, 3'b000};
        odd_tbl[2] = '{2, 3'b010, 3'b000};
        odd_tbl[3] = '{3, 3'b011, 3'b001};
        odd_tbl[4] = '{4, 3'b001, 3'b000};
        odd_tbl[5] = '{5, 3'b000, 3'b000};
        odd_tbl[6] = '{6, 3'b001, 3'b001};
        odd_tbl[7] = '{7, 3'b011, 3'b010};

        rst         = 1'b1;
        div_cfg     = '0;
        cfg_valid   = 1'b0;
        sync_req    = 1'b0;
        div_cfg_b   = '0;
        cfg_valid_b = 1'b0;
        sync_req_b  = 1'b0;

        // ---- Reset release with default divisors {100,4,1} ----
        tick();
        tick();
        chk("reset state", obs_a, 8'h00);
        rst = 1'b0;
        chk("first align", obs_a, 8'h00);
        tick();
        chk("first stb", {29'd0, outclk_stb}, 64'd7);
        run_check("default", 0, 210, 1, 4, 100);

        // ---- Odd divisors {0,7,3} ----
        chk("cfg_ready at T", {63'd0, cfg_ready}, 64'd1);
        div_cfg   = {16'd0, 16'd7, 16'd3};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("odd align", obs_a, 8'h00);
        tick();
        foreach (odd_tbl[j]) begin
            chk($sformatf("odd tbl k=%0d", odd_tbl[j].k),
                {58'd0, outclk, outclk_stb}, {58'd0, odd_tbl[j].exp_clk, odd_tbl[j].exp_stb});
            tick();
        end
        run_check("odd", 8, 13, 3, 7, 0);
        chk("odd coincide k=21", {61'd0, outclk_stb}, 64'd3);
        run_check("odd", 21, 20, 3, 7, 0);

        // ---- Back to {100,4,1}, then sync_req mid-period of ch2 ----
        div_cfg   = {16'd100, 16'd4, 16'd1};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("restore align", obs_a, 8'h00);
        tick();
        run_check("restore", 0, 137, 1, 4, 100);
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        chk("sync align", obs_a, 8'h00);
        // Offered during ALIGN: must be ignored.
        div_cfg   = {16'd5, 16'd5, 16'd5};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        run_check("post sync", 0, 40, 1, 4, 100);

        // ---- Simultaneous cfg {2,2,2} and sync_req ----
        div_cfg   = {16'd2, 16'd2, 16'd2};
        cfg_valid = 1'b1;
        sync_req  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        sync_req  = 1'b0;
        chk("cfg+sync align", obs_a, 8'h00);
        tick();
        run_check("div2", 0, 20, 2, 2, 2);

        // ---- Asynchronous reset mid-operation ----
        chk("pre reset k=20", obs_a, exp_a(20, 2, 2, 2));
        #2;
        rst = 1'b1;
        #1;
        chk("async reset", obs_a, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        chk("re-align", obs_a, 8'h00);
        tick();
        run_check("after reset", 0, 120, 1, 4, 100);

        // ---- Maximum divisor on the 4-bit instance (D=15) ----
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("max align", {60'd0, obs_b}, 64'd0);
        tick();
        for (int k = 0; k < 50; k++) begin
            chk($sformatf("max k=%0d", k), {60'd0, obs_b},
                {60'd0, ((k % 15) < 8), ((k % 15) == 0), (k >= LOCK_B), 1'b1});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
